siso_ram_seq: RTL and testbench



---
 rtl/siso_pkg.sv | 15 +
 rtl/siso_ram_seq_if.sv | 30 +++
 rtl/siso_skid2.sv | 63 ++++++
 rtl/siso_spram.sv | 28 ++
 rtl/siso_ram_seq.sv | 149 ++++++++++++++
 tb/tb_siso_ram_seq.sv | 317 +++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/siso_pkg.sv
// rtl/siso_pkg.sv - shared constants and state encoding for the SISO metric RAM sequencer
// Purpose: RAM geometry and the sequencer state type, imported by every file of the block.
package siso_pkg;

    localparam int unsigned ADDR_W  = 13;    // RAM address width
    localparam int unsigned DATA_W  = 16;    // metric word width
    localparam int unsigned MAX_LEN = 6148;  // RAM depth, largest legal block length

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/siso_ram_seq_if.sv
// rtl/siso_ram_seq_if.sv - control, write-stream and read-stream bundle of the sequencer
// Purpose: groups start/len/busy/err/done, the write stream and the read stream.
// Modports: master = block driving start/len/wr_*/rd_ready; slave = the sequencer.
interface siso_ram_seq_if;
    import siso_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] len;
    logic              busy;
    logic              err;
    logic              done;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              rd_ready;

    modport master (
        output start, len, wr_valid, wr_data, rd_ready,
        input  busy, err, done, wr_ready, rd_valid, rd_data, rd_last
    );

    modport slave (
        input  start, len, wr_valid, wr_data, rd_ready,
        output busy, err, done, wr_ready, rd_valid, rd_data, rd_last
    );

endinterface

// File: rtl/siso_skid2.sv
// rtl/siso_skid2.sv - 2-entry FIFO between the RAM dout and the read stream
// Ports: clk/rst; push_valid/push_data from the RAM read path (never pushed
// while full without a pop); pop_valid/pop_ready/pop_data toward the consumer;
// count = current occupancy, used by the read-issue logic.
module siso_skid2 #(
    parameter int unsigned W = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_valid,
    input  logic [W-1:0] push_data,
    output logic         pop_valid,
    input  logic         pop_ready,
    output logic [W-1:0] pop_data,
    output logic [1:0]   count
);

    logic [W-1:0] e0_q, e0_d;   // head entry
    logic [W-1:0] e1_q, e1_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         pop;

    assign pop_valid = (cnt_q != 2'd0);
    assign pop_data  = e0_q;
    assign count     = cnt_q;
    assign pop       = pop_valid & pop_ready;

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        if (pop) begin
            e0_d = e1_q;
        end
        unique case ({push_valid, pop})
            2'b10: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd0) e0_d = push_data;
                else               e1_d = push_data;
            end
            2'b01: cnt_d = cnt_q - 2'd1;
            // Simultaneous push/pop: the new word lands behind whatever remains.
            2'b11: begin
                if (cnt_q == 2'd1) e0_d = push_data;
                else               e1_d = push_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/siso_spram.sv
// rtl/siso_spram.sv - single-port read-first RAM with registered dout
// Ports: clk; en enables the access; we writes di at addr; dout returns the old
// contents of addr one cycle after an enabled access. Contents are never reset.
module siso_spram #(
    parameter int unsigned AW    = 13,
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 6148
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] di,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= di;
            end
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/siso_ram_seq.sv
// rtl/siso_ram_seq.sv - write-then-reverse-read sequencer for the SISO metric RAM
// Purpose: stores one block of N words at ascending addresses, then streams them
// back from address N-1 down to 0 with valid/ready backpressure.
// Ports: clk, rst (async, active-high); bus (slave modport): start/len request a
// block, busy/err/done report status, wr_* accept words, rd_* deliver them LIFO.
module siso_ram_seq
    import siso_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    siso_ram_seq_if.slave bus
);

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] n_q, n_d;
    logic [ADDR_W-1:0] wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic              issue_done_q, issue_done_d;        // address 0 already issued
    logic              inflight_q, inflight_d;            // RAM read issued last cycle
    logic              inflight_last_q, inflight_last_d;  // ... and it was address 0
    logic              err_q, err_d;
    logic              done_q, done_d;

    logic              len_ok;
    logic              issue;
    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_dout;
    logic              buf_valid;
    logic [DATA_W:0]   buf_data;    // {last, data}
    logic [1:0]        buf_count;
    logic              pop;
    logic [2:0]        occ;

    siso_spram #(.AW(ADDR_W), .DW(DATA_W), .DEPTH(MAX_LEN)) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (ram_addr),
        .di   (bus.wr_data),
        .dout (ram_dout)
    );

    siso_skid2 #(.W(DATA_W + 1)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push_valid (inflight_q),
        .push_data  ({inflight_last_q, ram_dout}),
        .pop_valid  (buf_valid),
        .pop_ready  (bus.rd_ready),
        .pop_data   (buf_data),
        .count      (buf_count)
    );

    assign len_ok   = (bus.len != '0) && (bus.len <= ADDR_W'(MAX_LEN));
    assign pop      = buf_valid & bus.rd_ready;
    assign occ      = {1'b0, buf_count} + {2'b00, inflight_q};
    assign ram_addr = (state_q == READ) ? raddr_q : wcnt_q;

    assign bus.busy     = (state_q != IDLE);
    assign bus.wr_ready = (state_q == WRITE);
    assign bus.err      = err_q;
    assign bus.done     = done_q;
    assign bus.rd_valid = buf_valid;
    assign bus.rd_data  = buf_data[DATA_W-1:0];
    assign bus.rd_last  = buf_valid & buf_data[DATA_W];

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        wcnt_d       = wcnt_q;
        raddr_d      = raddr_q;
        issue_done_d = issue_done_q;
        err_d        = 1'b0;
        done_d       = 1'b0;
        ram_en       = 1'b0;
        ram_we       = 1'b0;
        issue        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (len_ok) begin
                        n_d     = bus.len;
                        wcnt_d  = '0;
                        state_d = WRITE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (bus.wr_valid) begin
                    ram_en = 1'b1;
                    ram_we = 1'b1;
                    wcnt_d = wcnt_q + ADDR_W'(1);
                    if (wcnt_q == n_q - ADDR_W'(1)) begin
                        state_d      = READ;
                        raddr_d      = wcnt_q;
                        issue_done_d = 1'b0;
                    end
                end
            end
            READ: begin
                // Buffered + in-flight words after this cycle's pop must stay
                // within the 2 buffer slots, so a returning read always has room.
                issue = !issue_done_q && (occ < (3'd2 + {2'b00, pop}));
                if (issue) begin
                    ram_en = 1'b1;
                    if (raddr_q == '0) issue_done_d = 1'b1;
                    else               raddr_d      = raddr_q - ADDR_W'(1);
                end
                if (pop && buf_data[DATA_W]) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        inflight_d      = issue;
        inflight_last_d = issue && (raddr_q == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            n_q             <= '0;
            wcnt_q          <= '0;
            raddr_q         <= '0;
            issue_done_q    <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            err_q           <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            n_q             <= n_d;
            wcnt_q          <= wcnt_d;
            raddr_q         <= raddr_d;
            issue_done_q    <= issue_done_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            err_q           <= err_d;
            done_q          <= done_d;
        end
    end

endmodule

// File: tb/tb_siso_ram_seq.sv
// tb/tb_siso_ram_seq.sv - self-checking bench for siso_ram_seq
module tb_siso_ram_seq;
    import siso_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    siso_ram_seq_if bus ();

    siso_ram_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: words written are stacked; reads pop from the top.
    int          m_state = 0;     // 0 idle, 1 write, 2 read
    int          m_n     = 0;
    int          m_rcyc  = 0;
    logic        m_done  = 1'b0;
    logic        m_err   = 1'b0;
    logic        m_stalled = 1'b0;
    logic [15:0] words [$];
    logic [15:0] rd_log [$];
    logic        last_log [$];
    int          hs_cnt   = 0;
    int          done_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data;
    logic        prev_last;

    always @(negedge clk) begin
        logic        nd, ne;
        logic [15:0] exp_w;
        if (rst) begin
            m_state    = 0;
            words.delete();
            m_done     = 1'b0;
            m_err      = 1'b0;
            prev_stall = 1'b0;
        end else begin
            check("busy", bus.busy, m_state != 0);
            check("wr_ready", bus.wr_ready, m_state == 1);
            check("done", bus.done, m_done);
            check("err", bus.err, m_err);
            if (bus.done) done_cnt++;
            if (prev_stall) begin
                check("stall_valid", bus.rd_valid, 1);
                check("stall_data", bus.rd_data, prev_data);
                check("stall_last", bus.rd_last, prev_last);
            end
            nd = 1'b0;
            ne = 1'b0;
            case (m_state)
                0: begin
                    check("rd_valid_idle", bus.rd_valid, 0);
                    if (bus.start) begin
                        if (bus.len >= 1 && bus.len <= MAX_LEN) begin
                            m_state = 1;
                            m_n     = int'(bus.len);
                            words.delete();
                        end else begin
                            ne = 1'b1;
                        end
                    end
                end
                1: begin
                    check("rd_valid_write", bus.rd_valid, 0);
                    if (bus.wr_valid) begin
                        words.push_back(bus.wr_data);
                        if (words.size() == m_n) begin
                            m_state   = 2;
                            m_rcyc    = 0;
                            m_stalled = 1'b0;
                        end
                    end
                end
                default: begin
                    if (!bus.rd_ready) m_stalled = 1'b1;
                    if (m_rcyc < 2) check("rd_latency", bus.rd_valid, 0);
                    else if (!m_stalled) check("rd_stream", bus.rd_valid, 1);
                    if (bus.rd_valid && bus.rd_ready) begin
                        if (words.size() == 0) begin
                            check("extra_read", bus.rd_valid, 0);
                        end else begin
                            exp_w = words.pop_back();
                            check("rd_data", bus.rd_data, exp_w);
                            check("rd_last", bus.rd_last, words.size() == 0);
                            rd_log.push_back(bus.rd_data);
                            last_log.push_back(bus.rd_last);
                            hs_cnt++;
                            if (words.size() == 0) begin
                                m_state = 0;
                                nd      = 1'b1;
                            end
                        end
                    end
                    m_rcyc++;
                end
            endcase
            m_done     = nd;
            m_err      = ne;
            prev_stall = bus.rd_valid & ~bus.rd_ready;
            prev_data  = bus.rd_data;
            prev_last  = bus.rd_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        bus.start = 1'b1;
        bus.len   = n[12:0];
        tick();
        bus.start = 1'b0;
    endtask

    task automatic write_block(input logic [15:0] d [$], input int gap_max, input int mid_start_at);
        for (int i = 0; i < d.size(); i++) begin
            int g;
            int b;
            g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            repeat (g) begin
                bus.wr_valid = 1'b0;
                tick();
            end
            bus.wr_valid = 1'b1;
            bus.wr_data  = d[i];
            bus.start    = (i == mid_start_at);
            if (i == mid_start_at) bus.len = 13'd3;
            b = 0;
            @(negedge clk);
            while (!bus.wr_ready && b < 20) begin
                b++;
                @(negedge clk);
            end
            if (!bus.wr_ready) check("wr_ready_timeout", bus.wr_ready, 1);
            tick();
        end
        bus.wr_valid = 1'b0;
        bus.start    = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int b;
        b = 0;
        @(negedge clk);
        while (!bus.done && b < budget) begin
            b++;
            @(negedge clk);
        end
        if (!bus.done) check("done_timeout", bus.done, 1);
        tick();
    endtask

    initial begin
        logic [15:0] d [$];
        int          dc;
        int          hs0;
        int          b;
        logic        pat [9];

        bus.start    = 1'b0;
        bus.len      = '0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b1;

        #2 rst = 1'b1;
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_err", bus.err, 0);
        check("rst_wr_ready", bus.wr_ready, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_rd_last", bus.rd_last, 0);
        check("rst_done", bus.done, 0);
        #20;
        @(posedge clk);
        #2 rst = 1'b0;
        tick();

        // len=4 back-to-back, with a start pulse in mid-block
        rd_log.delete(); last_log.delete(); dc = done_cnt;
        do_start(4);
        d = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
        write_block(d, 0, 2);
        wait_done(20);
        check("t1_count", rd_log.size(), 4);
        if (rd_log.size() == 4) begin
            check("t1_w0", rd_log[0], 16'h0044);
            check("t1_w1", rd_log[1], 16'h0033);
            check("t1_w2", rd_log[2], 16'h0022);
            check("t1_w3", rd_log[3], 16'h0011);
            check("t1_last0", last_log[0], 0);
            check("t1_last3", last_log[3], 1);
        end
        check("t1_done_cnt", done_cnt - dc, 1);
        check("t1_idle", bus.busy, 0);

        // full-depth block with random write gaps
        rd_log.delete(); last_log.delete(); hs0 = hs_cnt;
        d.delete();
        for (int i = 0; i < 6148; i++) d.push_back(16'(i) ^ 16'hA5A5);
        do_start(6148);
        write_block(d, 2, -1);
        wait_done(6300);
        check("t2_handshakes", hs_cnt - hs0, 6148);
        if (rd_log.size() == 6148) begin
            check("t2_first", rd_log[0], 16'hBDA6);
            check("t2_final", rd_log[6147], 16'hA5A5);
        end

        // len=8 under a stall pattern
        rd_log.delete(); last_log.delete();
        d.delete();
        for (int i = 0; i < 8; i++) d.push_back(16'h0100 + 16'(i));
        do_start(8);
        write_block(d, 0, -1);
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 9; i++) begin
            bus.rd_ready = pat[i];
            tick();
        end
        bus.rd_ready = 1'b1;
        wait_done(40);
        check("t3_count", rd_log.size(), 8);
        if (rd_log.size() == 8) begin
            check("t3_first", rd_log[0], 16'h0107);
            check("t3_final", rd_log[7], 16'h0100);
            check("t3_last", last_log[7], 1);
        end

        // illegal lengths
        do_start(0);
        check("t4_err0", bus.err, 1);
        check("t4_busy0", bus.busy, 0);
        check("t4_wr_ready0", bus.wr_ready, 0);
        tick();
        check("t4_err_pulse", bus.err, 0);
        do_start(6149);
        check("t4_err_big", bus.err, 1);
        check("t4_busy_big", bus.busy, 0);
        check("t4_wr_ready_big", bus.wr_ready, 0);
        tick();

        // len=1
        rd_log.delete(); last_log.delete(); dc = done_cnt;
        do_start(1);
        d = '{16'hBEEF};
        write_block(d, 0, -1);
        wait_done(20);
        check("t5_count", rd_log.size(), 1);
        if (rd_log.size() == 1) begin
            check("t5_data", rd_log[0], 16'hBEEF);
            check("t5_last", last_log[0], 1);
        end
        check("t5_done_cnt", done_cnt - dc, 1);

        // reset after 3 reads of a len=6 block
        hs0 = hs_cnt;
        do_start(6);
        d = '{16'h0601, 16'h0602, 16'h0603, 16'h0604, 16'h0605, 16'h0606};
        write_block(d, 0, -1);
        b = 0;
        while (hs_cnt - hs0 < 3 && b < 30) begin
            b++;
            @(negedge clk);
        end
        check("t6_three_reads", hs_cnt - hs0, 3);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("t6_busy", bus.busy, 0);
        check("t6_err", bus.err, 0);
        check("t6_wr_ready", bus.wr_ready, 0);
        check("t6_rd_valid", bus.rd_valid, 0);
        check("t6_rd_data", bus.rd_data, 0);
        check("t6_rd_last", bus.rd_last, 0);
        check("t6_done", bus.done, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        tick();
        rd_log.delete(); last_log.delete();
        do_start(2);
        d = '{16'h1234, 16'h5678};
        write_block(d, 0, -1);
        wait_done(20);
        check("t6_count", rd_log.size(), 2);
        if (rd_log.size() == 2) begin
            check("t6_w0", rd_log[0], 16'h5678);
            check("t6_w1", rd_log[1], 16'h1234);
            check("t6_last0", last_log[0], 0);
            check("t6_last1", last_log[1], 1);
        end
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
